uart_tx_only: RTL and testbench

UART_TX_ONLY -- requirements
Module: uart_tx_only

---
 rtl/uart_tx_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 75 +++++++
 rtl/uart_tx_only.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_only.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared serializer states and frame constants for uart_tx_only
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit, 11-bit frame).
// Without it the frame is 8N1 (10 bits) and the PARITY state does not exist.
package uart_tx_pkg;

  localparam int STATE_W   = 3;
  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous show-ahead byte FIFO with registered ready flag
// Ports:
//   i_clk, i_rstn  : clock, asynchronous active-low reset
//   i_push, i_data : write strobe and byte
//   i_pop          : remove head (ignored while empty)
//   o_data         : head byte, valid while !o_empty
//   o_empty        : no bytes stored
//   o_ready        : registered, free entries >= parm_READY_FREE
//   o_drop         : pulse, push refused because FIFO full and not popping
module uart_tx_fifo #(
  parameter int parm_DEPTH      = 64,
  parameter int parm_READY_FREE = 34
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_data,
  output logic       o_empty,
  output logic       o_ready,
  output logic       o_drop
);

  localparam int AW = $clog2(parm_DEPTH);

  logic [7:0]    r_mem [parm_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ready;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [AW:0]   w_count_nxt;

  assign w_full  = (r_count == (AW+1)'(parm_DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && !w_push;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_ready = r_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
      // Built from the next occupancy so ready never lags what is stored:
      // a burst of parm_READY_FREE started while ready always fits.
      r_ready <= (((AW+1)'(parm_DEPTH) - w_count_nxt) >= (AW+1)'(parm_READY_FREE));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_only.sv
// rtl/uart_tx_only.sv - transmit-only UART with byte FIFO, 8N1 or 8E1 frames
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data bits).
// Ports:
//   i_clk_20mhz    : sole clock
//   i_rstn_20mhz   : asynchronous active-low reset, release synchronised internally
//   i_tx_data      : byte to enqueue
//   i_tx_valid     : enqueue strobe, one byte per high cycle
//   o_tx_ready     : registered, FIFO has >= parm_READY_FREE free entries
//   o_uart_txd     : serial line, idle high, driven from a flop
//   o_tx_overflow  : sticky, a byte was dropped on a full FIFO
//   o_tx_busy      : FIFO non-empty or a frame in progress
module uart_tx_only #(
  parameter int parm_CLK_HZ     = 20000000,
  parameter int parm_BAUD       = 115200,
  parameter int parm_FIFO_DEPTH = 64,
  parameter int parm_READY_FREE = 34
) (
  input  logic       i_clk_20mhz,
  input  logic       i_rstn_20mhz,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  output logic       o_uart_txd,
  output logic       o_tx_overflow,
  output logic       o_tx_busy
);

  import uart_tx_pkg::*;

  localparam int BIT_CLKS = (parm_CLK_HZ + parm_BAUD / 2) / parm_BAUD;
  localparam int CNT_W    = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  // Sized from the frame length so the index covers any frame position.
  localparam int IDX_W    = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CLKS - 1);

  logic [1:0]       r_rst_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_baud_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_txd;
  logic             r_overflow;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic       w_run;
  logic       w_bit_end;
  logic       w_pop;
  logic       w_empty;
  logic       w_drop;
  logic       w_ready;
  logic [7:0] w_fifo_data;

  uart_tx_fifo #(
    .parm_DEPTH      (parm_FIFO_DEPTH),
    .parm_READY_FREE (parm_READY_FREE)
  ) u_fifo (
    .i_clk   (i_clk_20mhz),
    .i_rstn  (i_rstn_20mhz),
    .i_push  (i_tx_valid),
    .i_data  (i_tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_empty (w_empty),
    .o_ready (w_ready),
    .o_drop  (w_drop)
  );

  // Reset asserts immediately; release is seen by the FSM two edges later.
  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) r_rst_sync <= 2'b00;
    else               r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_run     = r_rst_sync[1];
  assign w_bit_end = (r_baud_cnt == CNT_LAST);
  // A byte is taken from IDLE, or straight out of the last stop-bit cycle.
  assign w_pop     = w_run && !w_empty &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_overflow <= r_overflow | w_drop;
      r_baud_cnt <= ((r_state == S_IDLE) || w_bit_end) ? '0 : r_baud_cnt + 1'b1;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_fifo_data;
`endif
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_txd   <= r_parity;
`else
              r_state <= S_STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_txd     <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            if (w_pop) begin
              r_shift <= w_fifo_data;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_fifo_data;
`endif
              r_txd   <= 1'b0;
              r_state <= S_START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_uart_txd    = r_txd;
  assign o_tx_ready    = w_ready;
  assign o_tx_overflow = r_overflow;
  assign o_tx_busy     = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_tx_only.sv
// tb/tb_uart_tx_only.sv - directed self-checking bench for uart_tx_only
`timescale 1ns/1ps
module tb_uart_tx_only;

  // 20 MHz / 1081081 baud = 18.5000013 -> rounds to 19 clocks per bit.
  localparam int P = 19;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FP = FB * P;

  logic       clk;
  logic       rstn;
  logic       valid;
  logic [7:0] data;
  logic       ready;
  logic       txd;
  logic       ovf;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_events = 0;

  logic [7:0] mon_data[$];
  int         mon_start[$];
  logic       mon_par[$];
  int         mon_bad = 0;

  uart_tx_only #(
    .parm_CLK_HZ     (20000000),
    .parm_BAUD       (1081081),
    .parm_FIFO_DEPTH (64),
    .parm_READY_FREE (34)
  ) dut (
    .i_clk_20mhz   (clk),
    .i_rstn_20mhz  (rstn),
    .i_tx_data     (data),
    .i_tx_valid    (valid),
    .o_tx_ready    (ready),
    .o_uart_txd    (txd),
    .o_tx_overflow (ovf),
    .o_tx_busy     (busy)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rstn) rst_events = rst_events + 1;

  // Line receiver: samples mid-bit, drops frames hit by a reset.
  initial begin : monitor
    logic [7:0] b;
    logic       par;
    logic       okf;
    int         t0;
    int         r0;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        t0  = cyc;
        r0  = rst_events;
        okf = 1'b1;
        repeat (P / 2) @(negedge clk);
        if (txd !== 1'b0) okf = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (P) @(negedge clk);
          b[i] = txd;
        end
        par = 1'b0;
`ifdef UART_TX_PARITY_EN
        repeat (P) @(negedge clk);
        par = txd;
`endif
        repeat (P) @(negedge clk);
        if (txd !== 1'b1) okf = 1'b0;
        if (rst_events == r0) begin
          if (!okf) mon_bad++;
          mon_data.push_back(b);
          mon_start.push_back(t0);
          mon_par.push_back(par);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag, input int bound, output int fall);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    fall = cyc;
    check({tag, "_idle_in_time"}, 32'(n < bound), 32'd1);
  endtask

  initial begin : stim
    logic [10:0] exp_a;
    logic [7:0]  exp_b;
    int          fall;
    int          errs;
    int          gaps;

    rstn  = 1'b0;
    valid = 1'b0;
    data  = 8'h00;
    tick(3);
    check("rst_txd",   txd,   1);
    check("rst_ready", ready, 1);
    check("rst_ovf",   ovf,   0);
    check("rst_busy",  busy,  0);
    rstn = 1'b1;
    tick(5);

    // Single 0x41: start at N+2, then LSB-first data, parity, stop.
`ifdef UART_TX_PARITY_EN
    exp_a = {1'b1, 1'b0, 8'h41, 1'b0};
`else
    exp_a = {1'b0, 1'b1, 8'h41, 1'b0};
`endif
    data = 8'h41; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("a41_lat_n1", txd, 1);
    check("a41_busy_n1", busy, 1);
    @(negedge clk);
    for (int c = 0; c < FP; c++) begin
      if ((c % P) == 0 || (c % P) == P - 1)
        check($sformatf("a41_bit%0d_off%0d", c / P, c % P), txd, exp_a[c / P]);
      if (c == FP - 1) check("a41_busy_last_stop", busy, 1);
      @(negedge clk);
    end
    check("a41_busy_after", busy, 0);
    check("a41_txd_after", txd, 1);

`ifdef UART_TX_PARITY_EN
    mon_data.delete(); mon_start.delete(); mon_par.delete();
    data = 8'h07; valid = 1'b1;
    @(negedge clk);
    data = 8'h03;
    @(negedge clk);
    valid = 1'b0;
    wait_idle("par", 3 * FP, fall);
    check("par_count", mon_data.size(), 2);
    if (mon_data.size() >= 2) begin
      check("par_data0", mon_data[0], 8'h07);
      check("par_bit_07", mon_par[0], 1);
      check("par_data1", mon_data[1], 8'h03);
      check("par_bit_03", mon_par[1], 0);
      check("par_frame_len", mon_start[1] - mon_start[0], 11 * P);
    end
`endif

    // Burst of 34 while ready: back to back, no overflow.
    mon_data.delete(); mon_start.delete(); mon_par.delete();
    check("burst_ready_before", ready, 1);
    for (int i = 0; i < 34; i++) begin
      data  = (i < 32) ? 8'h20 : ((i == 32) ? 8'h0D : 8'h0A);
      valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    check("burst_ready_low", ready, 0);
    check("burst_ovf", ovf, 0);
    wait_idle("burst", 34 * FP + 50, fall);
    check("burst_count", mon_data.size(), 34);
    if (mon_data.size() == 34) begin
      errs = 0;
      gaps = 0;
      for (int i = 0; i < 34; i++) begin
        exp_b = (i < 32) ? 8'h20 : ((i == 32) ? 8'h0D : 8'h0A);
        if (mon_data[i] !== exp_b) errs++;
        if (i > 0 && (mon_start[i] - mon_start[i-1]) != FP) gaps++;
      end
      check("burst_data_errs", errs, 0);
      check("burst_gap_errs", gaps, 0);
      check("burst_busy_fall", fall, mon_start[33] + FP);
    end
    check("burst_ovf_end", ovf, 0);
    check("burst_ready_end", ready, 1);

    // Fill to 64, then push in the exact cycle the next byte is popped.
    mon_data.delete(); mon_start.delete(); mon_par.delete();
    for (int i = 0; i < 65; i++) begin
      data = 8'(i); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    check("full_count", dut.u_fifo.r_count, 64);
    check("full_ovf", ovf, 0);
    check("full_ready", ready, 0);
    tick(FP - 64);
    data = 8'hEE; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("pushpop_count", dut.u_fifo.r_count, 64);
    check("pushpop_ovf", ovf, 0);
    check("pushpop_start", txd, 0);
    wait_idle("pushpop", 67 * FP, fall);
    check("pushpop_tx_count", mon_data.size(), 66);
    if (mon_data.size() == 66) begin
      check("pushpop_byte64", mon_data[64], 8'd64);
      check("pushpop_last", mon_data[65], 8'hEE);
    end
    check("pushpop_ovf_end", ovf, 0);

    // 70 consecutive pushes: 65 survive, overflow sticks.
    mon_data.delete(); mon_start.delete(); mon_par.delete();
    for (int i = 0; i < 70; i++) begin
      data = 8'(i + 100); valid = 1'b1;
      @(negedge clk);
    end
    valid = 1'b0;
    check("ovf_set", ovf, 1);
    wait_idle("ovf", 70 * FP, fall);
    check("ovf_tx_count", mon_data.size(), 65);
    if (mon_data.size() == 65) begin
      errs = 0;
      for (int i = 0; i < 65; i++) if (mon_data[i] !== 8'(i + 100)) errs++;
      check("ovf_data_errs", errs, 0);
    end
    check("ovf_held", ovf, 1);

    // Reset in the middle of data bit 3 of 0xA5 with another byte queued.
    mon_data.delete(); mon_start.delete(); mon_par.delete();
    data = 8'hA5; valid = 1'b1;
    @(negedge clk);
    data = 8'h3C;
    @(negedge clk);
    valid = 1'b0;
    tick(4 * P + P / 2);
    check("rstmid_bit3_low", txd, 0);
    rstn = 1'b0;
    #1;
    check("rstmid_txd", txd, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_ready", ready, 1);
    check("rstmid_ovf", ovf, 0);
    check("rstmid_fifo", dut.u_fifo.r_count, 0);
    tick(4);
    rstn = 1'b1;
    tick(3 * FP);
    check("rstmid_no_frames", mon_data.size(), 0);
    check("rstmid_busy_after", busy, 0);
    check("rstmid_txd_after", txd, 1);

    // Push in the release cycle: FSM waits for the synchronised release.
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    data = 8'h5A; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("sync_n1", txd, 1);
    @(negedge clk);
    check("sync_n2", txd, 1);
    @(negedge clk);
    check("sync_n3_start", txd, 0);
    wait_idle("sync", 2 * FP, fall);
    check("sync_count", mon_data.size(), 1);
    if (mon_data.size() == 1) check("sync_data", mon_data[0], 8'h5A);

    check("framing_errs", mon_bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
